// File: rtl/alu_result_fifo.sv
// Purpose: collect registered ALU results {overflow, data} into a DEPTH-entry FIFO for a valid/ready consumer.
// Latency: an entry pushed at edge N is presented after edge N; there is no empty-bypass path from the inputs.
// Backpressure: none upstream; a result arriving while the FIFO is full with no pop is dropped and flagged on o_drop.
// Optional statistics counters are built when ALU_RESULT_FIFO_STATS_EN is defined.
module alu_result_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 12,
    parameter int CNT_W  = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clr,
    input  logic                       i_valid,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_overflow,
    output logic                       o_valid,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_overflow,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_drop
`ifdef ALU_RESULT_FIFO_STATS_EN
    ,
    output logic [CNT_W-1:0]           o_ovf_cnt,
    output logic [CNT_W-1:0]           o_drop_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Reject parameter sets the pointer arithmetic cannot handle.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_check
        $error("alu_result_fifo: DEPTH must be a power of two >= 2 and CNT_W >= 1");
    end

    logic [DATA_W:0]  mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    logic             drop_nxt;

    // Status comes from the registered count only, so the outputs never see i_valid/i_data directly.
    assign o_count  = count;
    assign o_full   = (count == CW'(DEPTH));
    assign o_empty  = (count == '0);
    assign o_valid  = !o_empty;

    // When full, a same-cycle pop frees the head slot, which equals wr_ptr and is reused by the push.
    assign pop      = o_valid && i_ready;
    assign push     = i_valid && (!o_full || pop);
    assign drop_nxt = i_valid && o_full && !pop;

    // Head entry is forced to zero whenever nothing valid is presented.
    assign o_data     = o_valid ? mem[rd_ptr][DATA_W-1:0] : '0;
    assign o_overflow = o_valid && mem[rd_ptr][DATA_W];

    // Storage is not reset; contents are only meaningful behind a nonzero count.
    always_ff @(posedge i_clk) begin
        if (push && !i_clr) begin
            mem[wr_ptr] <= {i_overflow, i_data};
        end
    end

    // Pointers, occupancy and the drop pulse; a flush overrides any same-cycle push or pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            o_drop <= 1'b0;
        end else if (i_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            o_drop <= 1'b0;
        end else begin
            o_drop <= drop_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef ALU_RESULT_FIFO_STATS_EN
    // Saturating event counters: overflowed results accepted, and results dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ovf_cnt  <= '0;
            o_drop_cnt <= '0;
        end else if (i_clr) begin
            o_ovf_cnt  <= '0;
            o_drop_cnt <= '0;
        end else begin
            if (push && i_overflow && (o_ovf_cnt != '1)) begin
                o_ovf_cnt <= o_ovf_cnt + CNT_W'(1);
            end
            if (drop_nxt && (o_drop_cnt != '1)) begin
                o_drop_cnt <= o_drop_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Purpose: directed scoreboard bench for alu_result_fifo.
// Latency: outputs sampled #1 after each rising edge; head checked before the edge it is popped on.
// Backpressure: i_ready driven per step; drops are predicted by a small occupancy model.
module tb_alu_result_fifo;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 12;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              vin = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              ovin = 1'b0;
    logic              rdy = 1'b0;
    logic              vout;
    logic [DATA_W-1:0] dout;
    logic              ovout;
    logic [3:0]        cnt;
    logic              full;
    logic              empty;
    logic              drop;
`ifdef ALU_RESULT_FIFO_STATS_EN
    logic [CNT_W-1:0]  ovf_cnt;
    logic [CNT_W-1:0]  drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [DATA_W:0] sb[$];
    int mcount = 0;

    alu_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
        .i_valid(vin), .i_data(din), .i_overflow(ovin),
        .o_valid(vout), .o_data(dout), .o_overflow(ovout),
        .i_ready(rdy), .o_count(cnt), .o_full(full), .o_empty(empty), .o_drop(drop)
`ifdef ALU_RESULT_FIFO_STATS_EN
        , .o_ovf_cnt(ovf_cnt), .o_drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"}, 32'(cnt), 32'(mcount));
        check({tag, ".valid"}, 32'(vout), 32'(mcount != 0));
        check({tag, ".empty"}, 32'(empty), 32'(mcount == 0));
        check({tag, ".full"}, 32'(full), 32'(mcount == DEPTH));
        if (mcount == 0) begin
            check({tag, ".zdata"}, 32'(dout), 32'h0);
            check({tag, ".zovf"}, 32'(ovout), 32'h0);
        end
    endtask

    // One clock step: drive at negedge, check/pop head before the edge, check status after it.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic ov,
                        input logic r, input logic c, input string tag);
        logic do_pop, do_push, exp_drop;
        @(negedge clk);
        vin = v; din = d; ovin = ov; rdy = r; clr = c;
        #1;
        do_pop   = (mcount != 0) && r;
        do_push  = v && ((mcount < DEPTH) || do_pop);
        exp_drop = v && (mcount == DEPTH) && !do_pop && !c;
        if (c) begin
            sb.delete();
            mcount = 0;
            exp_drop = 1'b0;
        end else begin
            if (do_pop) begin
                if (sb.size() == 0) begin
                    check({tag, ".sb_underflow"}, 32'(sb.size()), 32'd1);
                end else begin
                    logic [DATA_W:0] e;
                    e = sb.pop_front();
                    check({tag, ".data"}, 32'(dout), 32'(e[DATA_W-1:0]));
                    check({tag, ".ovf"}, 32'(ovout), 32'(e[DATA_W]));
                end
            end
            if (do_push) sb.push_back({ov, d});
            mcount = mcount + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        end
        @(posedge clk);
        #1;
        check({tag, ".drop"}, 32'(drop), 32'(exp_drop));
        check_status(tag);
        vin = 1'b0; rdy = 1'b0; clr = 1'b0;
    endtask

    initial begin
        // Reset state.
        #2;
        check("rst.valid", 32'(vout), 32'h0);
        check("rst.count", 32'(cnt), 32'h0);
        check("rst.empty", 32'(empty), 32'h1);
        check("rst.full", 32'(full), 32'h0);
        check("rst.drop", 32'(drop), 32'h0);
        check("rst.data", 32'(dout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push, held for 5 cycles, then one pop.
        step(1'b1, 12'h7FF, 1'b1, 1'b0, 1'b0, "single.push");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b0, "single.hold");
            check("single.hold_data", 32'(dout), 32'h7FF);
            check("single.hold_ovf", 32'(ovout), 32'h1);
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, "single.pop");

        // Fill, overflow drop, drain in order.
        for (int i = 1; i <= 8; i++) step(1'b1, 12'(i), 1'b0, 1'b0, 1'b0, "fill");
        step(1'b1, 12'd9, 1'b0, 1'b0, 1'b0, "fill.drop");
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, "fill.after_drop");
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, "drain");

        // Full with simultaneous push and pop.
        for (int i = 0; i < 8; i++) step(1'b1, 12'h10 + 12'(i), 1'b0, 1'b0, 1'b0, "fill2");
        step(1'b1, 12'hA5A, 1'b0, 1'b1, 1'b0, "full.pushpop");
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, "drain2");
        check("drain2.last_head", 32'(dout), 32'hA5A);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, "drain2.last");
        check("drain2.sb_empty", 32'(sb.size()), 32'd0);

        // Streaming push/pop across pointer wrap; ready while empty is ignored.
        for (int i = 0; i < 20; i++) step(1'b1, 12'h200 + 12'(i), 1'(i[0]), 1'b1, 1'b0, "stream");
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, "stream.tail");
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, "ready_empty");

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 5; i++) step(1'b1, 12'h300 + 12'(i), 1'b0, 1'b0, 1'b0, "q5");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(vout), 32'h0);
        check("arst.count", 32'(cnt), 32'h0);
        check("arst.data", 32'(dout), 32'h0);
        sb.delete();
        mcount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 12'h123, 1'b0, 1'b0, 1'b0, "arst.push");
        check("arst.head", 32'(dout), 32'h123);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, "arst.pop");

        // Synchronous flush with entries queued; same-cycle push/pop ignored.
        for (int i = 0; i < 5; i++) step(1'b1, 12'h400 + 12'(i), 1'b1, 1'b0, 1'b0, "q5b");
        step(1'b1, 12'hFFF, 1'b1, 1'b1, 1'b1, "clr");
        step(1'b1, 12'h123, 1'b0, 1'b0, 1'b0, "clr.push");
        check("clr.head", 32'(dout), 32'h123);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, "clr.pop");

`ifdef ALU_RESULT_FIFO_STATS_EN
        // Saturating statistics counters.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, "stats.clr0");
        check("stats.ovf0", 32'(ovf_cnt), 32'h0);
        check("stats.drop0", 32'(drop_cnt), 32'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 12'h500 + 12'(i), 1'b1, 1'b0, 1'b0, "stats.ovf");
        for (int i = 0; i < 3; i++) step(1'b1, 12'h600 + 12'(i), 1'b0, 1'b0, 1'b0, "stats.fill");
        for (int i = 0; i < 4; i++) step(1'b1, 12'h700 + 12'(i), 1'b1, 1'b0, 1'b0, "stats.drop");
        check("stats.ovf_sat", 32'(ovf_cnt), 32'h3);
        check("stats.drop_sat", 32'(drop_cnt), 32'h3);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, "stats.clr");
        check("stats.ovf_clr", 32'(ovf_cnt), 32'h0);
        check("stats.drop_clr", 32'(drop_cnt), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream collection stage for the 12-bit signed ALU.
- Captures each registered ALU result (valid, data, overflow flag) into a small FIFO.
- Presents results to a consumer through a valid/ready handshake.
- The ALU has no backpressure, so results arriving while the FIFO is full are dropped and flagged.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, minimum 2.
- DATA_W, 12, result data width; matches the ALU output.
- CNT_W, 8, width of the statistics counters (optional feature only).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_clr  input  1  synchronous flush; empties the FIFO and clears the statistics.
- i_valid  input  1  ALU result valid; connects to ALU o_valid.
- i_data  input  DATA_W  ALU result; connects to ALU o_data.
- i_overflow  input  1  ALU overflow flag; connects to ALU o_overflow.
- o_valid  output  1  head entry available to the consumer.
- o_data  output  DATA_W  head entry data.
- o_overflow  output  1  head entry overflow flag.
- i_ready  input  1  consumer accepts the head entry this cycle.
- o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_full  output  1  occupancy == DEPTH.
- o_empty  output  1  occupancy == 0.
- o_drop  output  1  one-cycle pulse: an input was discarded because the FIFO was full.

Behaviour:
- Reset (asynchronous):
  - Read/write pointers and count go to 0.
  - o_valid=0, o_data=0, o_overflow=0, o_full=0, o_empty=1, o_drop=0.
  - Storage contents are don't-care.
- Storage: each entry is {overflow, data}, DATA_W+1 bits, stored unmodified (no sign manipulation).
- Push condition: i_valid && (!o_full || pop).
  - Writes the entry at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop condition: o_valid && i_ready; rd_ptr increments modulo DEPTH.
- Count updates:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, including when full (the freed slot is reused in the same cycle).
- Latency:
  - An entry pushed at edge N is visible on o_valid/o_data/o_overflow after edge N.
  - No combinational path from i_valid or i_data to the outputs. There is no empty-bypass: pushing into an empty FIFO sets o_valid starting the following cycle.
- Output stability: o_valid, o_data and o_overflow hold stable while o_valid=1 and i_ready=0.
- Empty outputs: o_data=0 and o_overflow=0 whenever o_valid=0.
- o_valid equals !o_empty.
- Full with no pop: i_valid is discarded and o_drop is high the next cycle. FIFO contents and pointers are unchanged.
- i_clr:
  - Pointers and count go to 0 at the next edge; any push or pop in the same cycle is ignored.
  - o_drop is 0 the next cycle.
  - Statistics counters clear.
- i_ready while empty: ignored; no pointer movement.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from count, not from pointer equality.
- Reset mid-operation: all entries are lost; no partial output is held.

Optional Feature:
- Macro: ALU_RESULT_FIFO_STATS_EN.
- Defined: adds output ports o_ovf_cnt [CNT_W-1:0] and o_drop_cnt [CNT_W-1:0], both reset to 0 and cleared by i_clr.
  - o_ovf_cnt increments on every accepted push with i_overflow=1.
  - o_drop_cnt increments on every dropped input.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Counts are visible one cycle after the event.
- Not defined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset, then single push i_data=12'h7FF with i_overflow=1 and i_ready=0 -> next cycle o_valid=1, o_data=12'h7FF, o_overflow=1, o_count=1; held stable for 5 cycles; one cycle of i_ready=1 -> o_valid=0, o_data=0, o_empty=1.
- Push 8 values 1..8 with i_ready=0 -> o_full=1, o_count=8; push 9 -> o_drop pulses once and count stays 8; drain with i_ready=1 -> outputs 1..8 in order.
- Full FIFO, simultaneous i_valid (data=12'hA5A) and i_ready=1 -> no drop, count stays 8, head advances, 12'hA5A appears last after draining.
- Continuous push and pop for 20 cycles with i_ready=1 (pointer wrap) -> every value emitted in order exactly once, count never exceeds 1.
- Assert i_rst_n low with 5 entries queued -> o_valid=0, o_count=0 immediately (asynchronously); after release, a new push of 12'h123 is the first output. Repeat with i_clr -> same result one edge later.
- With STATS_EN and CNT_W=2: 5 overflowed pushes plus 4 drops -> o_ovf_cnt=3 and o_drop_cnt=3 (saturated); i_clr -> both 0.
